// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam int unsigned PC_INCR      = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory, redirect and decode-side signals of the fetch unit.
interface instruction_fetch_unit_if #(
    parameter int unsigned N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;
    logic         redirect_valid;
    logic [N-1:0] redirect_pc;
    logic         inst_valid;
    logic [N-1:0] inst_data;
    logic [N-1:0] inst_pc;
    logic         inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc,
        output inst_ready
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small sync FIFO of {pc, instr} with flush and a registered head.
module instruction_fetch_unit_fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  din_i,
    output logic [CW-1:0] count_o,
    output logic          valid_o,
    output logic [W-1:0]  head_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          valid_q, valid_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push = push_i && !flush_i;
        do_pop  = pop_i && (cnt_q != '0) && !flush_i;
        rd_d    = flush_i ? '0 : rd_q + AW'(do_pop);
        wr_d    = flush_i ? '0 : wr_q + AW'(do_push);
        cnt_d   = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
        valid_d = (cnt_d != '0);
        // Head bypasses the array when the new head is written this cycle.
        head_d  = (do_push && (wr_q == rd_d)) ? din_i : mem_q[rd_d];
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = valid_q;
    assign head_o  = head_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, sequences single-outstanding
// imem reads and buffers instructions toward decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEF),
    parameter int unsigned  DEPTH    = 4
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e   state_q;
    logic [N-1:0]   fetch_pc_q;
    logic [N-1:0]   addr_q;
    logic           req_q;

    logic [CW-1:0]  count;
    logic           fifo_valid;
    logic [2*N-1:0] head;
    logic           push, pop, full;
    logic [N-1:0]   redir_pc;

    assign redir_pc = {bus.redirect_pc[N-1:2], 2'b00};
    assign full     = (count == CW'(DEPTH));
    assign push     = (state_q == S_WAIT) && bus.imem_ack
                   && !bus.redirect_valid;
    assign pop      = fifo_valid && bus.inst_ready;

    instruction_fetch_unit_fetch_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .din_i   ({fetch_pc_q, bus.imem_rdata}),
        .count_o (count),
        .valid_o (fifo_valid),
        .head_o  (head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_q <= redir_pc;
                    end else if (!full) begin
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_q <= redir_pc;
                        if (bus.imem_ack) begin
                            req_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end else if (bus.imem_ack) begin
                        fetch_pc_q <= fetch_pc_q + N'(PC_INCR);
                        req_q      <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    // Stale request stays up until memory answers it.
                    if (bus.redirect_valid) fetch_pc_q <= redir_pc;
                    if (bus.imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = fifo_valid;
    assign bus.inst_pc    = head[2*N-1:N];
    assign bus.inst_data  = head[N-1:0];
endmodule
